// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core package for the writeback arbiter slice.
// Provides the register-file geometry constants (address width, data width,
// register count), the starvation counter width, the grant encoding used
// between the grant controller and the top level, and a small helper that
// says whether a destination register is architecturally writable.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int REG_CNT    = 32;
  localparam int STARVE_W   = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REQ0 = 2'd1,
    GNT_REQ1 = 2'd2
  } grant_e;

  // x0 is hardwired to zero: writes to it are accepted but discarded.
  function automatic logic rd_writable(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: two valid/ready requesters (req0 = single-cycle ALU,
// req1 = long-latency LSU/MDU), each carrying a destination register and data.
//   master : requester side, drives valid/rd/data, receives ready
//   slave  : arbiter side, receives valid/rd/data, drives ready
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [REG_ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0]     req0_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [REG_ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0]     req1_data;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_grant_ctrl.sv
// wb_grant_ctrl: fixed-priority grant (req0 first) with starvation relief for
// req1. After STARVE_LIMIT consecutive cycles in which req1 was valid but lost,
// req1 wins the next contended cycle.
// Ports: clk, rst (sync, active-high), req0_valid, req1_valid (in);
//        req0_ready, req1_ready (combinational, mutually exclusive), grant (out).
module wb_grant_ctrl
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   req0_valid,
  input  logic   req1_valid,
  output logic   req0_ready,
  output logic   req1_ready,
  output grant_e grant
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;

  // Requests are ignored outright while reset is asserted.
  always_comb begin
    grant = GNT_NONE;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant = (starve_cnt == LIMIT) ? GNT_REQ1 : GNT_REQ0;
      end else if (req0_valid) begin
        grant = GNT_REQ0;
      end else if (req1_valid) begin
        grant = GNT_REQ1;
      end
    end
  end

  assign req0_ready = (grant == GNT_REQ0);
  assign req1_ready = (grant == GNT_REQ1);

  // Counts consecutive lost cycles of req1; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (req1_valid && (grant != GNT_REQ1)) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + STARVE_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two writeback requesters onto the single
// register-file write port and keeps the scoreboard (busy table) of registers
// with an outstanding writeback.
// Ports: clk, rst (sync, active-high);
//        wb (slave modport): req0/req1 valid/ready/rd/data;
//        issue_en, issue_rd: mark a destination pending;
//        rs1_addr/rs2_addr -> rs1_busy/rs2_busy: combinational hazard query;
//        rf_we, rf_rd, rf_wdata: registered regfile write drive (1-cycle latency).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   wb,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0]     rf_wdata
);

  grant_e grant;

  wb_grant_ctrl #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (wb.req0_valid),
    .req1_valid (wb.req1_valid),
    .req0_ready (wb.req0_ready),
    .req1_ready (wb.req1_ready),
    .grant      (grant)
  );

  // Stage p0: select the winning request
  logic                  vld_p0;
  logic [REG_ADDR_W-1:0] rd_p0;
  logic [DATA_W-1:0]     data_p0;

  always_comb begin
    vld_p0  = 1'b0;
    rd_p0   = wb.req0_rd;
    data_p0 = wb.req0_data;
    if (grant == GNT_REQ0) begin
      vld_p0 = 1'b1;
    end else if (grant == GNT_REQ1) begin
      vld_p0  = 1'b1;
      rd_p0   = wb.req1_rd;
      data_p0 = wb.req1_data;
    end
  end

  // Stage p1: registered regfile write; rd/data only move on a real write
  logic                  vld_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic [DATA_W-1:0]     data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0 && rd_writable(rd_p0);
      if (vld_p0 && rd_writable(rd_p0)) begin
        rd_p1   <= rd_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign rf_we    = vld_p1;
  assign rf_rd    = rd_p1;
  assign rf_wdata = data_p1;

  // Busy table: cleared by the write leaving stage p1, set by issue; set wins.
  logic [REG_CNT-1:0] busy_q;
  logic [REG_CNT-1:0] set_vec;
  logic [REG_CNT-1:0] clr_vec;
  logic [REG_CNT-1:0] busy_nxt;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_en && rd_writable(issue_rd)) set_vec[issue_rd] = 1'b1;
    if (vld_p1) clr_vec[rd_p1] = 1'b1;
    busy_nxt    = (busy_q & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  assign rs1_busy = rd_writable(rs1_addr) && busy_q[rs1_addr];
  assign rs2_busy = rd_writable(rs2_addr) && busy_q[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en;
  logic [4:0]  issue_rd, rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter_if wb ();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_wdata (rf_wdata)
  );

  always #5 clk = ~clk;

  // Reference model: counts req1's losing streak, a bit per register, and the
  // write the port will show after the edge.
  int          m_lost;
  bit          m_busy [32];
  bit          m_we;
  int          m_rd;
  logic [31:0] m_data;

  // 0 = nobody, 1 = req0, 2 = req1
  function automatic int model_winner();
    if (rst) return 0;
    if (wb.req0_valid && wb.req1_valid) return (m_lost >= LIMIT) ? 2 : 1;
    if (wb.req0_valid) return 1;
    if (wb.req1_valid) return 2;
    return 0;
  endfunction

  task automatic clock_edge();
    int w;
    int wrd;
    logic [31:0] wdat;
    w = model_winner();
    wrd  = (w == 2) ? int'(wb.req1_rd) : int'(wb.req0_rd);
    wdat = (w == 2) ? wb.req1_data : wb.req0_data;
    @(posedge clk);
    if (rst) begin
      m_lost = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
      m_we = 0; m_rd = 0; m_data = '0;
    end else begin
      if (m_we) m_busy[m_rd] = 0;
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1;
      if (wb.req1_valid && w != 2) m_lost = (m_lost < LIMIT) ? m_lost + 1 : LIMIT;
      else m_lost = 0;
      m_we = (w != 0) && (wrd != 0);
      if (m_we) begin m_rd = wrd; m_data = wdat; end
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb.req0_valid = 0; wb.req1_valid = 0;
    wb.req0_rd = '0; wb.req1_rd = '0; wb.req0_data = '0; wb.req1_data = '0;
    issue_en = 0; issue_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); rs1_addr = 5'd4; rs2_addr = 5'd0;
    wb.req0_valid = 1; wb.req0_rd = 5'd4; wb.req0_data = 32'h1111_2222;
    wb.req1_valid = 1; wb.req1_rd = 5'd6;
    issue_en = 1; issue_rd = 5'd4;
    #1;
    total++; if (wb.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b want=0", wb.req0_ready); end
    total++; if (wb.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b want=0", wb.req1_ready); end
    clock_edge(); clock_edge();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", rf_we); end
    total++; if (rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d want=0", rf_rd); end
    total++; if (rf_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", rf_wdata); end
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL reset_busy4 got=%b want=0", rs1_busy); end
    rst = 0; idle_inputs();
    clock_edge();
  endtask

  task automatic test_single_req0();
    wb.req0_valid = 1; wb.req0_rd = 5'd5; wb.req0_data = 32'hDEADBEEF;
    #1;
    total++; if (wb.req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b want=1", wb.req0_ready); end
    total++; if (wb.req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready1 got=%b want=0", wb.req1_ready); end
    clock_edge();
    idle_inputs();
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b want=1", rf_we); end
    total++; if (rf_rd !== 5'd5) begin bad++; $display("FAIL single_rd got=%0d want=5", rf_rd); end
    total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%h want=deadbeef", rf_wdata); end
    clock_edge();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_we_drop got=%b want=0", rf_we); end
    total++; if (rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_hold got=%0d/%h want=5/deadbeef", rf_rd, rf_wdata); end
  endtask

  task automatic test_starvation();
    bit want1 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    wb.req0_valid = 1; wb.req1_valid = 1;
    wb.req1_rd = 5'd2; wb.req1_data = 32'hB000_0000;
    for (int i = 0; i < 8; i++) begin
      wb.req0_rd = 5'd1; wb.req0_data = 32'hA000_0000 + 32'(i);
      #1;
      total++;
      if (wb.req1_ready !== logic'(want1[i]) || wb.req0_ready !== logic'(!want1[i])) begin
        bad++; $display("FAIL starve_cycle%0d got=r0:%b r1:%b want r1=%0d", i, wb.req0_ready, wb.req1_ready, want1[i]);
      end
      clock_edge();
      total++;
      if (rf_rd !== (want1[i] ? 5'd2 : 5'd1)) begin
        bad++; $display("FAIL starve_wb%0d got rd=%0d want=%0d", i, rf_rd, want1[i] ? 2 : 1);
      end
      if (want1[i]) wb.req1_data = wb.req1_data + 32'd1;
    end
    idle_inputs();
    clock_edge();
  endtask

  task automatic test_busy();
    rs1_addr = 5'd7;
    issue_en = 1; issue_rd = 5'd7;
    #1;
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL busy_nobypass got=%b want=0", rs1_busy); end
    clock_edge();
    issue_en = 0;
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL busy_set got=%b want=1", rs1_busy); end
    wb.req1_valid = 1; wb.req1_rd = 5'd7; wb.req1_data = 32'h0000_0077;
    #1;
    total++; if (wb.req1_ready !== 1'b1) begin bad++; $display("FAIL busy_ready1 got=%b want=1", wb.req1_ready); end
    clock_edge();
    idle_inputs();
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h77) begin bad++; $display("FAIL busy_wb got=%b/%0d/%h want=1/7/77", rf_we, rf_rd, rf_wdata); end
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL busy_still got=%b want=1", rs1_busy); end
    clock_edge();
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL busy_clear got=%b want=0", rs1_busy); end
  endtask

  task automatic test_set_clear_same();
    rs2_addr = 5'd9;
    issue_en = 1; issue_rd = 5'd9;
    clock_edge();
    issue_en = 0;
    wb.req0_valid = 1; wb.req0_rd = 5'd9; wb.req0_data = 32'h9999;
    clock_edge();
    idle_inputs();
    issue_en = 1; issue_rd = 5'd9;
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd9) begin bad++; $display("FAIL setclr_wb got=%b/%0d want=1/9", rf_we, rf_rd); end
    clock_edge();
    issue_en = 0;
    total++; if (rs2_busy !== 1'b1) begin bad++; $display("FAIL setclr_setwins got=%b want=1", rs2_busy); end
    clock_edge();
    total++; if (rs2_busy !== 1'b1) begin bad++; $display("FAIL setclr_keep got=%b want=1", rs2_busy); end
  endtask

  task automatic test_rd_zero();
    rs1_addr = 5'd0;
    wb.req0_valid = 1; wb.req0_rd = 5'd0; wb.req0_data = 32'h1234;
    #1;
    total++; if (wb.req0_ready !== 1'b1) begin bad++; $display("FAIL rd0_ready got=%b want=1", wb.req0_ready); end
    clock_edge();
    idle_inputs();
    issue_en = 1; issue_rd = 5'd0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rd0_we got=%b want=0", rf_we); end
    total++; if (rf_rd !== 5'd9 || rf_wdata !== 32'h9999) begin bad++; $display("FAIL rd0_hold got=%0d/%h want=9/9999", rf_rd, rf_wdata); end
    clock_edge();
    issue_en = 0;
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL rd0_busy got=%b want=0", rs1_busy); end
  endtask

  task automatic test_reset_mid();
    bit want1 [4] = '{0, 0, 0, 1};
    rs1_addr = 5'd3;
    issue_en = 1; issue_rd = 5'd3;
    wb.req0_valid = 1; wb.req0_rd = 5'd4; wb.req0_data = 32'h44;
    wb.req1_valid = 1; wb.req1_rd = 5'd6; wb.req1_data = 32'h66;
    clock_edge();
    issue_en = 0;
    rst = 1;
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_pre got=%b want=1", rs1_busy); end
    clock_edge();
    rst = 0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%b want=0", rf_we); end
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", rs1_busy); end
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (wb.req1_ready !== logic'(want1[i])) begin bad++; $display("FAIL rmid_starve%0d got=%b want=%0d", i, wb.req1_ready, want1[i]); end
      clock_edge();
    end
    idle_inputs();
    clock_edge();
  endtask

  task automatic test_random();
    int w;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!wb.req0_valid || wb.req0_ready) begin
        wb.req0_valid = ($urandom_range(0, 2) != 0);
        wb.req0_rd = 5'($urandom_range(0, 31)); wb.req0_data = $urandom;
      end
      if (!wb.req1_valid || wb.req1_ready) begin
        wb.req1_valid = ($urandom_range(0, 2) != 0);
        wb.req1_rd = 5'($urandom_range(0, 31)); wb.req1_data = $urandom;
      end
      issue_en = ($urandom_range(0, 1) != 0);
      issue_rd = 5'($urandom_range(0, 31));
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      #1;
      w = model_winner();
      total++;
      if (wb.req0_ready !== logic'(w == 1) || wb.req1_ready !== logic'(w == 2)) begin
        bad++; $display("FAIL rnd_grant c=%0d got=%b%b want winner=%0d", c, wb.req0_ready, wb.req1_ready, w);
      end
      total++;
      if (rs1_busy !== logic'(m_busy[rs1_addr]) || rs2_busy !== logic'(m_busy[rs2_addr])) begin
        bad++; $display("FAIL rnd_busy c=%0d got=%b%b want=%b%b", c, rs1_busy, rs2_busy, m_busy[rs1_addr], m_busy[rs2_addr]);
      end
      clock_edge();
      total++;
      if (rf_we !== m_we || rf_rd !== 5'(m_rd) || rf_wdata !== m_data) begin
        bad++; $display("FAIL rnd_wb c=%0d got=%b/%0d/%h want=%b/%0d/%h", c, rf_we, rf_rd, rf_wdata, m_we, m_rd, m_data);
      end
    end
    rst = 0; idle_inputs();
    clock_edge();
  endtask

  initial begin
    m_lost = 0; m_we = 0; m_rd = 0; m_data = '0;
    foreach (m_busy[i]) m_busy[i] = 0;
    test_reset();
    test_single_req0();
    test_starvation();
    test_busy();
    test_set_clear_same();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
